output_queue_scheduler: RTL



---
 rtl/output_queue_scheduler_pkg.sv | 18 +
 rtl/output_queue_scheduler_rr_pick.sv | 30 +++
 rtl/output_queue_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/output_queue_scheduler_pkg.sv
// Shared definitions for the output-port packet scheduler.
package output_queue_scheduler_pkg;

  localparam int PRI_NUM_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2,
    ST_XFER  = 2'd3
  } sched_state_e;

  typedef enum logic {
    SCHED_SP  = 1'b0,
    SCHED_WRR = 1'b1
  } sched_scheme_e;

endpackage

// File: rtl/output_queue_scheduler_rr_pick.sv
// Rotating first-one finder: first set bit of i_elig at or above i_start,
// wrapping N-1 -> 0. N need not be a power of two.
module output_queue_scheduler_rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_elig,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  int w_k;

  // Scan N slots starting at i_start; first eligible slot wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      w_k = int'(i_start) + i;
      if (w_k >= N) w_k = w_k - N;
      if (!o_found && i_elig[w_k]) begin
        o_found = 1'b1;
        o_idx   = W'(w_k);
      end
    end
  end

endmodule

// File: rtl/output_queue_scheduler.sv
// Per-output-port scheduler: strict priority or credit WRR arbitration,
// then one packet per grant via grant/ack/done handshake.
module output_queue_scheduler
  import output_queue_scheduler_pkg::*;
#(
  parameter  int PRI_NUM  = PRI_NUM_DEF,
  parameter  int WEIGHT_W = 4,
  localparam int PRI_W    = $clog2(PRI_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PRI_NUM-1:0]            queue_nempty,
  input  logic [PRI_NUM*WEIGHT_W-1:0]   weights,
  input  logic                          select_scheme,
  input  logic                          sched_en,
  output logic [PRI_W-1:0]              grant_queue,
  output logic                          grant_vld,
  input  logic                          grant_ack,
  input  logic                          pkt_done,
  output logic                          busy
);

  sched_state_e           r_state;
  logic [PRI_W-1:0]       r_sel;
  logic [PRI_W-1:0]       r_rr_ptr;
  logic                   r_wrr;       // scheme latched when r_sel was chosen
  logic [WEIGHT_W-1:0]    r_credit [PRI_NUM];

  logic [WEIGHT_W-1:0]    w_weight [PRI_NUM];
  logic [PRI_NUM-1:0]     w_elig;
  logic [PRI_W-1:0]       w_rr_idx;
  logic                   w_rr_found;
  logic [PRI_W-1:0]       w_sp_idx;
  logic                   w_any;
  logic [WEIGHT_W-1:0]    w_cur_credit;
  logic [WEIGHT_W-1:0]    w_dec_credit;
  logic [PRI_W-1:0]       w_ptr_inc;

  genvar gq;
  generate
    for (gq = 0; gq < PRI_NUM; gq++) begin : g_q
      assign w_weight[gq] = weights[gq*WEIGHT_W +: WEIGHT_W];
      assign w_elig[gq]   = queue_nempty[gq] && (r_credit[gq] != '0);
    end
  endgenerate

  assign w_any        = |queue_nempty;
  assign w_cur_credit = r_credit[r_sel];
  // Saturating decrement: a credit never wraps below zero.
  assign w_dec_credit = (w_cur_credit == '0) ? '0 : w_cur_credit - 1'b1;
  assign w_ptr_inc    = (r_sel == PRI_W'(PRI_NUM-1)) ? '0 : r_sel + 1'b1;

  output_queue_scheduler_rr_pick #(.N(PRI_NUM), .W(PRI_W)) u_rr_pick (
    .i_elig  (w_elig),
    .i_start (r_rr_ptr),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  // Strict priority: highest nonempty index wins (last hit in ascending scan).
  always_comb begin
    w_sp_idx = '0;
    for (int q = 0; q < PRI_NUM; q++)
      if (queue_nempty[q]) w_sp_idx = PRI_W'(q);
  end

  // Scheduler FSM with credit and round-robin pointer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_wrr    <= 1'b0;
      for (int q = 0; q < PRI_NUM; q++) r_credit[q] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sched_en && w_any) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (!w_any) begin
            r_state <= ST_IDLE;
          end else if (sched_scheme_e'(select_scheme) == SCHED_WRR) begin
            r_wrr <= 1'b1;
            if (w_rr_found) begin
              r_sel   <= w_rr_idx;
              r_state <= ST_GRANT;
            end else begin
              // Nobody eligible: refill every queue, weight 0 counts as 1,
              // and re-arbitrate next cycle.
              for (int q = 0; q < PRI_NUM; q++)
                r_credit[q] <= (w_weight[q] == '0) ? WEIGHT_W'(1) : w_weight[q];
            end
          end else begin
            r_wrr   <= 1'b0;
            r_sel   <= w_sp_idx;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Ack takes precedence over a simultaneous queue drain.
          if (grant_ack) begin
            r_state <= ST_XFER;
            if (r_wrr) begin
              r_credit[r_sel] <= w_dec_credit;
              r_rr_ptr        <= (w_dec_credit == '0) ? w_ptr_inc : r_sel;
            end
          end else if (!queue_nempty[r_sel]) begin
            r_state <= ST_ARB;
          end
        end
        ST_XFER: begin
          if (pkt_done) r_state <= (sched_en && w_any) ? ST_ARB : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_vld   = (r_state == ST_GRANT);
  assign grant_queue = r_sel;
  assign busy        = (r_state != ST_IDLE);

endmodule
